// File: rtl/regfile_md_unit.sv
// Register file with NUM_RD combinational read ports, HI/LO pair and an iterative mul/div engine.
// Optional write-first read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_md_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     hilo_wr_en,
    input  logic                     hilo_sel,
    input  logic [DATA_W-1:0]        hilo_wdata,
    output logic [DATA_W-1:0]        hilo_rdata,
    input  logic                     md_start,
    input  logic [1:0]               md_op,
    input  logic [DATA_W-1:0]        md_a,
    input  logic [DATA_W-1:0]        md_b,
    output logic                     md_busy,
    output logic                     md_done
);
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int CNT_W    = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    typedef struct packed {
        logic              div;
        logic              res_neg;
        logic              rem_neg;
        logic [DATA_W-1:0] opnd;
    } md_req_t;

    state_t state, state_nx;
    md_req_t req;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [DATA_W-1:0]               hi, lo;
    logic [2*DATA_W-1:0]             acc;
    logic [CNT_W-1:0]                cnt;

    // ---------------- register file ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs <= '0;
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign rd_data[i*DATA_W +: DATA_W] =
            (wr_en && wr_addr != '0 && ra == wr_addr) ? wr_data : regs[ra];
`else
        assign rd_data[i*DATA_W +: DATA_W] = regs[ra];
`endif
    end

    // ---------------- mul/div engine ----------------
    logic              start_ok, div_zero, a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;

    assign start_ok = md_start && (state == IDLE || state == DONE);
    assign div_zero = md_op[1] && (md_b == '0);
    assign a_neg    = md_op[0] & md_a[DATA_W-1];
    assign b_neg    = md_op[0] & md_b[DATA_W-1];
    assign a_mag    = a_neg ? -md_a : md_a;
    assign b_mag    = b_neg ? -md_b : md_b;

    // acc holds {partial product | multiplier} or {remainder | dividend->quotient}
    logic [DATA_W:0]     mul_sum, div_diff;
    logic [2*DATA_W-1:0] mul_step, div_step;

    assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, req.opnd & {DATA_W{acc[0]}}};
    assign mul_step = {mul_sum, acc[DATA_W-1:1]};
    assign div_diff = acc[2*DATA_W-1:DATA_W-1] - {1'b0, req.opnd};
    assign div_step = div_diff[DATA_W] ? {acc[2*DATA_W-2:0], 1'b0}
                                       : {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
            req <= '0;
        end else if (start_ok) begin
            cnt         <= CNT_W'(DATA_W);
            req.div     <= md_op[1];
            req.res_neg <= !div_zero && (a_neg ^ b_neg);
            req.rem_neg <= !div_zero && a_neg;
            req.opnd    <= md_op[1] ? b_mag : a_mag;
            // divide by zero preloads the final {HI, LO} so FIX passes it straight through
            if (div_zero)
                acc <= {md_a, {DATA_W{1'b1}}};
            else
                acc <= {{DATA_W{1'b0}}, md_op[1] ? a_mag : b_mag};
        end else if (state == RUN) begin
            cnt <= cnt - CNT_W'(1);
            acc <= req.div ? div_step : mul_step;
        end
    end

    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo, rem, fix_hi, fix_lo;

    assign prod   = req.res_neg ? -acc : acc;
    assign quo    = req.res_neg ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    assign rem    = req.rem_neg ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
    assign fix_hi = req.div ? rem : prod[2*DATA_W-1:DATA_W];
    assign fix_lo = req.div ? quo : prod[DATA_W-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = md_start ? (div_zero ? FIX : RUN) : IDLE;
            RUN:        if (cnt == CNT_W'(1)) state_nx = FIX;
            FIX:        state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    assign md_busy = (state == RUN) || (state == FIX);
    assign md_done = (state == DONE);

    // ---------------- HI/LO ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            hi <= fix_hi;
            lo <= fix_lo;
        end else if (hilo_wr_en && !md_busy) begin
            if (hilo_sel) hi <= hilo_wdata;
            else          lo <= hilo_wdata;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign hilo_rdata = (hilo_wr_en && !md_busy) ? hilo_wdata : (hilo_sel ? hi : lo);
`else
    assign hilo_rdata = hilo_sel ? hi : lo;
`endif

endmodule

// File: tb/tb_regfile_md_unit.sv
// Randomized bench for regfile_md_unit against a cycle-level behavioural model.
module tb_regfile_md_unit;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic              clock, reset;
    logic              wr_en, hilo_wr_en, hilo_sel, md_start, md_busy, md_done;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data, hilo_wdata, hilo_rdata, md_a, md_b;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [1:0]        md_op;

    regfile_md_unit #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clock(clock), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .hilo_wr_en(hilo_wr_en), .hilo_sel(hilo_sel), .hilo_wdata(hilo_wdata),
        .hilo_rdata(hilo_rdata),
        .md_start(md_start), .md_op(md_op), .md_a(md_a), .md_b(md_b),
        .md_busy(md_busy), .md_done(md_done)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    int          m_left = 0;   // cycles the engine still reports busy
    bit          m_done = 0;

    function automatic logic [63:0] md_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (op)
            2'd0: res = 64'(a) * 64'(b);
            2'd1: begin p = sa * sb; res = p; end
            2'd2: res = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: begin
                if (b == 0) res = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
            m_left = 0; m_done = 0;
        end else begin
            logic [63:0] res;
            if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
            m_done = (m_left == 1);
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin m_hi = m_phi; m_lo = m_plo; end
            end else begin
                if (hilo_wr_en) begin
                    if (hilo_sel) m_hi = hilo_wdata;
                    else          m_lo = hilo_wdata;
                end
                if (md_start) begin
                    res = md_ref(md_op, md_a, md_b);
                    m_phi = res[63:32];
                    m_plo = res[31:0];
                    m_left = (md_op[1] && md_b == 0) ? 1 : DW + 1;
                end
            end
        end
    end

    function automatic logic [31:0] m_read(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr != 0 && a == wr_addr) return wr_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic [31:0] m_hilo();
`ifdef REGFILE_BYPASS_EN
        if (hilo_wr_en && m_left == 0) return hilo_wdata;
`endif
        return hilo_sel ? m_hi : m_lo;
    endfunction

    always @(negedge clock) begin
        if (chk_on) begin
            for (int i = 0; i < NR; i++)
                chk("rd_data", rd_data[i*DW +: DW], m_read(rd_addr[i*AW +: AW]));
            chk("hilo_rdata", hilo_rdata, m_hilo());
            chk("md_busy", 32'(md_busy), 32'(m_left != 0));
            chk("md_done", 32'(md_done), 32'(m_done));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic peek(input logic sel, output logic [31:0] v);
        hilo_sel = sel;
        #1;
        v = hilo_rdata;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op = op; md_a = a; md_b = b; md_start = 1;
        tick();
        md_start = 0;
    endtask

    task automatic wait_done(output int busy_cyc);
        busy_cyc = md_busy ? 1 : 0;
        for (int i = 0; i < 100 && !md_done; i++) begin
            tick();
            if (md_busy) busy_cyc++;
        end
        chk("done_seen", 32'(md_done), 32'd1);
    endtask

    task automatic check_hilo(input string name, input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] v;
        peek(1'b1, v); chk({name, "_hi"}, v, ehi);
        peek(1'b0, v); chk({name, "_lo"}, v, elo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        int bc;
        logic [31:0] v;
        reset = 1;
        wr_en = 0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        hilo_wr_en = 0; hilo_sel = 0; hilo_wdata = '0;
        md_start = 0; md_op = '0; md_a = '0; md_b = '0;
        repeat (2) @(posedge clock);
        chk_on = 1;
        #1;
        rd_addr = {5'd0, 5'd5};
        #1;
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_done", 32'(md_done), 32'd0);
        chk("rst_rd", rd_data[31:0], 32'd0);
        check_hilo("rst", 32'd0, 32'd0);
        tick();
        reset = 0;

        // register writes, r0 stays zero
        wr_en = 1; wr_addr = 5'd5; wr_data = 32'h12345678;
        tick();
        wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        tick();
        wr_en = 0; rd_addr = {5'd0, 5'd5};
        #1;
        chk("r5", rd_data[31:0], 32'h12345678);
        chk("r0", rd_data[63:32], 32'h0);

        // mult -3 * 7
        start_op(2'b01, 32'hFFFFFFFD, 32'd7);
        wait_done(bc);
        chk("mult_busy_cycles", bc, 32'd33);
        check_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);

        // div -7 / 2, then divu 100 / 7 started from DONE
        start_op(2'b11, 32'hFFFFFFF9, 32'd2);
        wait_done(bc);
        check_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
        start_op(2'b10, 32'd100, 32'd7);
        wait_done(bc);
        check_hilo("divu", 32'd2, 32'd14);

        // divide by zero, then a start accepted while in DONE
        start_op(2'b10, 32'h55, 32'h0);
        wait_done(bc);
        chk("dz_busy_cycles", bc, 32'd1);
        check_hilo("dz", 32'h55, 32'hFFFFFFFF);
        start_op(2'b11, 32'h80000000, 32'hFFFFFFFF);
        chk("start_in_done", 32'(md_busy), 32'd1);
        wait_done(bc);
        chk("ovf_busy_cycles", bc, 32'd33);
        check_hilo("ovf", 32'h0, 32'h80000000);

        // reset mid-operation
        start_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) tick();
        reset = 1;
        #1;
        chk("abort_busy", 32'(md_busy), 32'd0);
        chk("abort_done", 32'(md_done), 32'd0);
        check_hilo("abort", 32'd0, 32'd0);
        tick();
        reset = 0;
        start_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(bc);
        check_hilo("multu", 32'hFFFFFFFE, 32'h00000001);
        tick();

        // mthi/mtlo while idle; mthi during busy is dropped
        hilo_wr_en = 1; hilo_sel = 1; hilo_wdata = 32'hAA;
        tick();
        hilo_sel = 0; hilo_wdata = 32'hBB;
        tick();
        hilo_wr_en = 0;
        check_hilo("mthilo", 32'hAA, 32'hBB);
        start_op(2'b00, 32'd2, 32'd3);
        repeat (3) tick();
        hilo_wr_en = 1; hilo_sel = 1; hilo_wdata = 32'hDEAD;
        tick();
        hilo_wr_en = 0;
        peek(1'b1, v);
        chk("stale_hi", v, 32'hAA);
        wait_done(bc);
        check_hilo("mul23", 32'd0, 32'd6);

        // same-cycle write/read of r3
        wr_en = 1; wr_addr = 5'd3; wr_data = 32'h11;
        tick();
        wr_data = 32'd7; rd_addr = {5'd0, 5'd3};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_r3", rd_data[31:0], 32'd7);
`else
        chk("nobypass_r3", rd_data[31:0], 32'h11);
`endif
        tick();
        wr_en = 0;
        #1;
        chk("r3_after", rd_data[31:0], 32'd7);

        // randomized traffic, checked by the per-cycle compare process
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 299) == 0);
            wr_en      = $urandom_range(0, 1) == 1;
            wr_addr    = 5'($urandom_range(0, 31));
            wr_data    = $urandom();
            rd_addr    = 10'($urandom_range(0, 1023));
            hilo_wr_en = ($urandom_range(0, 3) == 0);
            hilo_sel   = $urandom_range(0, 1) == 1;
            hilo_wdata = $urandom();
            md_start   = ($urandom_range(0, 7) == 0);
            md_op      = 2'($urandom_range(0, 3));
            md_a       = pick();
            md_b       = pick();
            tick();
        end
        reset = 0; md_start = 0; hilo_wr_en = 0; wr_en = 0;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_md_unit.md
Name: regfile_md_unit

Overview:
- Parametrised next-generation register file for the single-cycle CPU.
- Adds N read ports, a HI/LO pair, and an integrated iterative multiply/divide engine with a start/busy/done handshake.
- Sits in the decode stage. The datapath selects write-back data externally and presents one write per cycle.
- The controller stalls on md_busy; this replaces the old one-cycle HI/LO write path.

Parameters:
- DATA_W, 32, register/HI/LO width.
- ADDR_W, 5, register address width; 2^ADDR_W registers.
- NUM_RD, 2, number of combinational read ports.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- wr_en  in  1  register write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, same packing.
- hilo_wr_en  in  1  mthi/mtlo write.
- hilo_sel  in  1  0 = LO, 1 = HI; used for hilo_wr_en and hilo_rdata.
- hilo_wdata  in  DATA_W  mthi/mtlo data.
- hilo_rdata  out  DATA_W  mfhi/mflo read data, combinational.
- md_start  in  1  start a multiply/divide.
- md_op  in  2  00 multu, 01 mult, 10 divu, 11 div.
- md_a  in  DATA_W  multiplicand/dividend, sampled on start.
- md_b  in  DATA_W  multiplier/divisor, sampled on start.
- md_busy  out  1  engine running; HI/LO not valid.
- md_done  out  1  one-cycle pulse; HI/LO just updated.

Behaviour:
- Reset (async): all registers, HI, LO = 0; FSM to IDLE; md_busy = 0, md_done = 0. Asserting reset mid-operation aborts the operation and leaves HI/LO = 0.
- Register 0 reads 0 always. Writes to address 0 are dropped.
- Register write takes effect on the rising edge when wr_en = 1. Reads are combinational.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE: md_start = 1 at edge E0 latches the operands and md_op, and goes to RUN. Counter = DATA_W. md_busy = 1 from E0.
- Signed ops (01, 11): operands are converted to magnitudes at latch time. Result signs are recorded:
  - product: negative if signs differ;
  - quotient: negative if signs differ;
  - remainder: takes the sign of the dividend.
- RUN, multiply: radix-2 shift-add on a 2*DATA_W accumulator, one bit per cycle.
- RUN, divide: restoring division, one quotient bit per cycle.
- RUN exits to FIX after DATA_W iterations, at edge E_W.
- FIX: applies sign correction and writes HI/LO at E_{W+1}.
  - multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - divide: LO = quotient, HI = remainder.
  - Transitions to DONE.
- DONE: md_done = 1 and md_busy = 0 for exactly one cycle, then IDLE. Total start-to-done latency is DATA_W+1 edges; 33 at the default width.
- md_start in DONE is accepted as if in IDLE, so back-to-back operations lose no cycle.
- Divide by zero (md_b = 0, op 10/11): skip RUN. FIX occurs at E1 with HI = md_a (raw) and LO = all ones. md_done is high after E1.
- Signed overflow case (div, most-negative value / -1): LO = most-negative value, HI = 0; no trap.
- md_start while md_busy = 1: ignored, operands not relatched.
- hilo_wr_en while md_busy = 1: ignored. The controller must stall.
- hilo_wr_en and FIX completion on the same edge: the engine result wins.
- hilo_rdata while md_busy = 1 returns the stale HI/LO. The controller stalls mfhi/mflo on md_busy.
- hilo_wr_en in IDLE/DONE writes the selected HI or LO at the edge; the other is unchanged.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-first forwarding. If wr_en = 1, wr_addr != 0 and rd_addr[i] == wr_addr, then rd_data[i] = wr_data in the same cycle. hilo_rdata likewise forwards hilo_wdata on a matching hilo_sel write.
- Undefined: reads return the stored value; the new value is visible from the cycle after the edge.

Test Plan:
- Reset, write 0x12345678 to r5 and 0xFFFFFFFF to r0, read ports at 5 and 0 -> 0x12345678 and 0x00000000.
- mult md_a = 0xFFFFFFFD (-3), md_b = 7 -> md_busy for 33 cycles, then md_done one cycle; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- div md_a = 0xFFFFFFF9 (-7), md_b = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. divu 100/7 -> LO = 14, HI = 2.
- divu md_a = 0x55, md_b = 0 -> md_done after 1 cycle; HI = 0x55, LO = 0xFFFFFFFF. A subsequent md_start during DONE is accepted.
- Start multu 0xFFFFFFFF*0xFFFFFFFF, assert reset at cycle 10 -> busy/done = 0, HI = LO = 0, FSM IDLE. Re-run to completion -> HI = 0xFFFFFFFE, LO = 0x00000001.
- mthi 0xAA then mtlo 0xBB while idle; issue mthi during busy -> ignored. With REGFILE_BYPASS_EN, write r3 = 7 with read r3 in the same cycle -> rd_data = 7; without the macro -> old value.
